arm_fetch_stage: RTL and testbench



---
 rtl/arm_fetch_stage.sv | 158 +++++++++++++++
 tb/tb_arm_fetch_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_fetch_stage.sv
// ARM9TDMI instruction fetch front end: issues word fetches, buffers returned words in a
// small prefetch queue, and loads IR/IR_PC with a one-cycle FETCH_EN pulse per new instruction.
module arm_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic        FETCH_EN
);

    localparam int unsigned  PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int unsigned  CNT_W    = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [31:0]  RESET_PC = RESET_VECTOR & ~32'h3;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        inflight_addr_q, inflight_addr_d;
    logic               outstanding_q, outstanding_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        ir_q, ir_d;
    logic [31:0]        ir_pc_q, ir_pc_d;
    logic               fetch_en_q, fetch_en_d;

    logic [31:0]        q_data_q [QUEUE_DEPTH];
    logic [31:0]        q_addr_q [QUEUE_DEPTH];

    logic               rsp_valid;
    logic               req;
    logic               issue;
    logic               push;
    logic               pop;

    // A response only counts when we are waiting for one; anything else predates a reset.
    assign rsp_valid = IMEM_RVALID && outstanding_q;

    // Queue slots already promised (held + in flight) must leave room for the new request.
    assign req = !RST && (state_q == ST_RUN) && !BRANCH_TAKEN
               && (!outstanding_q || rsp_valid)
               && (({1'b0, count_q} + {{CNT_W{1'b0}}, outstanding_q}) < DEPTH_W);

    assign issue = req && IMEM_ACK;
    assign push  = rsp_valid && (state_q == ST_RUN) && !BRANCH_TAKEN;
    assign pop   = (count_q != '0) && !STALL && !BRANCH_TAKEN;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        inflight_addr_d = inflight_addr_q;
        outstanding_d   = outstanding_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        ir_d            = ir_q;
        ir_pc_d         = ir_pc_q;
        fetch_en_d      = 1'b0;

        if (rsp_valid) begin
            outstanding_d = 1'b0;
        end

        if (issue) begin
            outstanding_d   = 1'b1;
            inflight_addr_d = fetch_pc_q;
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end

        if (pop) begin
            ir_d       = q_data_q[head_q];
            ir_pc_d    = q_addr_q[head_q];
            head_d     = head_q + PTR_W'(1);
            fetch_en_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase

        if ((state_q == ST_FLUSH) && rsp_valid) begin
            state_d = ST_RUN;
        end

        // A redirect wins over everything; a request still in flight must be drained in FLUSH.
        if (BRANCH_TAKEN) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = BRANCH_TARGET & ~32'h3;
            state_d    = outstanding_d ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_RUN;
            fetch_pc_q      <= RESET_PC;
            inflight_addr_q <= '0;
            outstanding_q   <= 1'b0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            ir_q            <= '0;
            ir_pc_q         <= '0;
            fetch_en_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            inflight_addr_q <= inflight_addr_d;
            outstanding_q   <= outstanding_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            ir_q            <= ir_d;
            ir_pc_q         <= ir_pc_d;
            fetch_en_q      <= fetch_en_d;
        end
    end

    // NOTE: queue storage is not reset; count_q guards every read, so stale slots are never seen.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_data_q[tail_q] <= IMEM_RDATA;
            q_addr_q[tail_q] <= inflight_addr_q;
        end
    end

    assign IMEM_REQ  = req;
    assign IMEM_ADDR = fetch_pc_q;
    assign IR        = ir_q;
    assign IR_PC     = ir_pc_q;
    assign FETCH_EN  = fetch_en_q;

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Directed bench for arm_fetch_stage: behavioural instruction memory with selectable latency,
// logs of issued addresses and loaded instructions, and hand-computed expectations.
module tb_arm_fetch_stage;

    localparam int unsigned QUEUE_DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b1;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'h0;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic        FETCH_EN;

    int n_checks = 0;
    int n_fail   = 0;
    int overflow_cnt = 0;
    int mem_lat = 1;

    logic [31:0] ir_pc_log [$];
    logic [31:0] ir_log    [$];
    logic [31:0] issue_log [$];

    arm_fetch_stage #(
        .RESET_VECTOR (32'h0000_0000),
        .QUEUE_DEPTH  (QUEUE_DEPTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_ACK      (IMEM_ACK),
        .IMEM_RVALID   (IMEM_RVALID),
        .IMEM_RDATA    (IMEM_RDATA),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IR            (IR),
        .IR_PC         (IR_PC),
        .FETCH_EN      (FETCH_EN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hE1A0_5A00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: one pending read, data returned mem_lat cycles after the issuing edge.
    logic        m_iss, m_cons;
    logic [31:0] m_addr;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr  = 32'h0;
    int          pend_wait  = 0;

    always begin
        @(negedge CLK);
        m_iss  = IMEM_REQ && IMEM_ACK;
        m_addr = IMEM_ADDR;
        m_cons = IMEM_RVALID;
        @(posedge CLK);
        #1;
        if (m_cons) pend_valid = 1'b0;
        if (m_iss) begin
            pend_valid = 1'b1;
            pend_addr  = m_addr;
            pend_wait  = mem_lat - 1;
        end else if (pend_valid && pend_wait != 0) begin
            pend_wait = pend_wait - 1;
        end
        IMEM_RVALID = pend_valid && (pend_wait == 0);
        IMEM_RDATA  = IMEM_RVALID ? word_of(pend_addr) : 32'hDEAD_BEEF;
    end

    always @(negedge CLK) begin
        if (FETCH_EN) begin
            ir_pc_log.push_back(IR_PC);
            ir_log.push_back(IR);
        end
        if (IMEM_REQ && IMEM_ACK) issue_log.push_back(IMEM_ADDR);
        if (dut.push && !dut.pop && (dut.count_q == QUEUE_DEPTH)) overflow_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int lat);
        RST = 1'b1;
        STALL = 1'b0;
        BRANCH_TAKEN = 1'b0;
        IMEM_ACK = 1'b1;
        mem_lat = lat;
        repeat (2) step();
        @(negedge CLK);
        check("rst_req", {31'b0, IMEM_REQ}, 32'd0);
        check("rst_fetch_en", {31'b0, FETCH_EN}, 32'd0);
        check("rst_ir", IR, 32'h0);
        check("rst_ir_pc", IR_PC, 32'h0);
        step();
        RST = 1'b0;
        ir_pc_log.delete();
        ir_log.delete();
        issue_log.delete();
    endtask

    task automatic wait_loads(input int n, input string tag);
        int cyc = 0;
        while (ir_pc_log.size() < n && cyc < 100) begin
            step();
            cyc++;
        end
        check(tag, 32'(ir_pc_log.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Sequential fetch, first-load latency, then a 10-cycle stall and release.
        do_reset(1);
        @(negedge CLK);
        check("t1_first_req", {31'b0, IMEM_REQ}, 32'd1);
        check("t1_first_addr", IMEM_ADDR, 32'h0);
        repeat (3) step();
        STALL = 1'b1;
        @(negedge CLK);
        check("t1_lat_fetch_en", {31'b0, FETCH_EN}, 32'd1);
        check("t1_lat_ir_pc", IR_PC, 32'h0);
        check("t1_lat_ir", IR, word_of(32'h0));
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge CLK);
            check("t2_stall_fetch_en", {31'b0, FETCH_EN}, 32'd0);
            check("t2_stall_ir_pc", IR_PC, 32'h0);
            check("t2_stall_ir", IR, word_of(32'h0));
        end
        check("t2_stall_req_low", {31'b0, IMEM_REQ}, 32'd0);
        check("t2_stall_issues", 32'(issue_log.size()), 32'd3);
        step();
        STALL = 1'b0;
        wait_loads(5, "t2_loads");
        if (ir_pc_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check("t2_ir_pc_seq", ir_pc_log[k], 32'(4 * k));
                check("t2_ir_seq", ir_log[k], word_of(32'(4 * k)));
            end
        end
        if (issue_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) check("t1_addr_seq", issue_log[k], 32'(4 * k));
        end

        // Redirect while a 3-cycle read is outstanding: stale word must be dropped.
        do_reset(3);
        step();
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h0000_0103;
        step();
        BRANCH_TAKEN = 1'b0;
        @(negedge CLK);
        check("t3_flush_req", {31'b0, IMEM_REQ}, 32'd0);
        check("t3_flush_fetch_en", {31'b0, FETCH_EN}, 32'd0);
        step();
        @(negedge CLK);
        check("t3_rsp_cycle_req", {31'b0, IMEM_REQ}, 32'd0);
        step();
        @(negedge CLK);
        check("t3_redirect_req", {31'b0, IMEM_REQ}, 32'd1);
        check("t3_redirect_addr", IMEM_ADDR, 32'h0000_0100);
        wait_loads(1, "t3_loads");
        if (ir_pc_log.size() >= 1) begin
            check("t3_ir_pc", ir_pc_log[0], 32'h0000_0100);
            check("t3_ir", ir_log[0], word_of(32'h0000_0100));
        end

        // Redirect in the same cycle as RVALID with a non-empty queue and STALL released.
        do_reset(1);
        STALL = 1'b1;
        repeat (2) step();
        STALL         = 1'b0;
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h0000_0200;
        step();
        BRANCH_TAKEN = 1'b0;
        @(negedge CLK);
        check("t4_fetch_en", {31'b0, FETCH_EN}, 32'd0);
        check("t4_ir_kept", IR, 32'h0);
        check("t4_ir_pc_kept", IR_PC, 32'h0);
        check("t4_queue_empty", 32'(dut.count_q), 32'd0);
        check("t4_req", {31'b0, IMEM_REQ}, 32'd1);
        check("t4_addr", IMEM_ADDR, 32'h0000_0200);
        wait_loads(1, "t4_loads");
        if (ir_pc_log.size() >= 1) begin
            check("t4_ir_pc", ir_pc_log[0], 32'h0000_0200);
            check("t4_ir", ir_log[0], word_of(32'h0000_0200));
        end

        // Fetch PC wrap from the top of the address space.
        do_reset(1);
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        step();
        BRANCH_TAKEN = 1'b0;
        wait_loads(2, "t5_loads");
        if (issue_log.size() >= 2) begin
            check("t5_addr_top", issue_log[0], 32'hFFFF_FFFC);
            check("t5_addr_wrap", issue_log[1], 32'h0);
        end
        if (ir_pc_log.size() >= 2) begin
            check("t5_ir_pc_top", ir_pc_log[0], 32'hFFFF_FFFC);
            check("t5_ir_pc_wrap", ir_pc_log[1], 32'h0);
            check("t5_ir_wrap", ir_log[1], word_of(32'h0));
        end

        // Reset with a read outstanding; its late response must be ignored.
        do_reset(3);
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h0000_0040;
        step();
        BRANCH_TAKEN = 1'b0;
        @(negedge CLK);
        check("t6_pre_req", {31'b0, IMEM_REQ}, 32'd1);
        check("t6_pre_addr", IMEM_ADDR, 32'h0000_0040);
        step();
        RST = 1'b1;
        @(negedge CLK);
        check("t6_rst_req", {31'b0, IMEM_REQ}, 32'd0);
        step();
        RST = 1'b0;
        IMEM_ACK = 1'b0;
        ir_pc_log.delete();
        ir_log.delete();
        @(negedge CLK);
        check("t6_post_req", {31'b0, IMEM_REQ}, 32'd1);
        check("t6_post_addr", IMEM_ADDR, 32'h0);
        check("t6_post_fetch_en", {31'b0, FETCH_EN}, 32'd0);
        check("t6_post_ir", IR, 32'h0);
        step();
        @(negedge CLK);
        check("t6_stale_fetch_en", {31'b0, FETCH_EN}, 32'd0);
        check("t6_stale_addr", IMEM_ADDR, 32'h0);
        step();
        IMEM_ACK = 1'b1;
        mem_lat  = 1;
        wait_loads(1, "t6_loads");
        if (ir_pc_log.size() >= 1) begin
            check("t6_ir_pc", ir_pc_log[0], 32'h0);
            check("t6_ir", ir_log[0], word_of(32'h0));
        end

        check("no_overflow", 32'(overflow_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
